// File: rtl/mdr_arbiter.sv
// Two-requester round-robin front end for a shared MDR multiply/divide engine.
// Latches the winner's operands, starts the engine, and returns the result or a timeout.
module mdr_arbiter #(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned MAX_WAIT    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [1:0]             op0,
    input  logic [1:0]             op1,
    input  logic [WORD_LENGTH-1:0] x0,
    input  logic [WORD_LENGTH-1:0] y0,
    input  logic [WORD_LENGTH-1:0] x1,
    input  logic [WORD_LENGTH-1:0] y1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic                   done0,
    output logic                   done1,
    output logic [WORD_LENGTH-1:0] res_result,
    output logic [WORD_LENGTH-1:0] res_remainder,
    output logic                   res_sign,
    output logic                   res_err,
    output logic                   busy,
    output logic [WORD_LENGTH-1:0] mdr_dataX,
    output logic [WORD_LENGTH-1:0] mdr_dataY,
    output logic [1:0]             mdr_op,
    output logic                   mdr_start,
    input  logic                   mdr_ready,
    input  logic [WORD_LENGTH-1:0] mdr_result,
    input  logic [WORD_LENGTH-1:0] mdr_remainder,
    input  logic                   mdr_sign
);

    localparam int unsigned CntWidth = $clog2(MAX_WAIT + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MAX_WAIT);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StIssue  = 3'd1;
    localparam logic [2:0] StSettle = 3'd2;
    localparam logic [2:0] StWait   = 3'd3;
    localparam logic [2:0] StResp   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic                   winner_q, winner_d;
    logic                   last_grant_q, last_grant_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [1:0]             op_q, op_d;
    logic [WORD_LENGTH-1:0] x_q, x_d;
    logic [WORD_LENGTH-1:0] y_q, y_d;
    logic [WORD_LENGTH-1:0] result_q, result_d;
    logic [WORD_LENGTH-1:0] remainder_q, remainder_d;
    logic                   sign_q, sign_d;
    logic                   err_q, err_d;
    logic                   gnt0_q, gnt0_d;
    logic                   gnt1_q, gnt1_d;
    logic                   done0_q, done0_d;
    logic                   done1_q, done1_d;
    logic                   start_q, start_d;
    logic                   pick1;

    // On a tie the requester that did not win last time goes next.
    assign pick1 = (req0 && req1) ? ~last_grant_q : req1;

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        x_d          = x_q;
        y_d          = y_q;
        result_d     = result_q;
        remainder_d  = remainder_q;
        sign_d       = sign_q;
        err_d        = err_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        start_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    winner_d     = pick1;
                    last_grant_d = pick1;
                    op_d         = pick1 ? op1 : op0;
                    x_d          = pick1 ? x1 : x0;
                    y_d          = pick1 ? y1 : y0;
                    gnt0_d       = ~pick1;
                    gnt1_d       = pick1;
                    start_d      = 1'b1;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                state_d = StSettle;
            end
            StSettle: begin
                // A level ready left over from the previous job is still visible here.
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (mdr_ready) begin
                    result_d    = mdr_result;
                    remainder_d = mdr_remainder;
                    sign_d      = mdr_sign;
                    err_d       = 1'b0;
                    done0_d     = ~winner_q;
                    done1_d     = winner_q;
                    state_d     = StResp;
                end else if (cnt_q == CntMax) begin
                    result_d    = '0;
                    remainder_d = '0;
                    sign_d      = 1'b0;
                    err_d       = 1'b1;
                    done0_d     = ~winner_q;
                    done1_d     = winner_q;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            op_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            result_q     <= '0;
            remainder_q  <= '0;
            sign_q       <= 1'b0;
            err_q        <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            x_q          <= x_d;
            y_q          <= y_d;
            result_q     <= result_d;
            remainder_q  <= remainder_d;
            sign_q       <= sign_d;
            err_q        <= err_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            start_q      <= start_d;
        end
    end

    assign gnt0          = gnt0_q;
    assign gnt1          = gnt1_q;
    assign done0         = done0_q;
    assign done1         = done1_q;
    assign mdr_start     = start_q;
    assign busy          = (state_q != StIdle);
    assign mdr_op        = op_q;
    assign mdr_dataX     = x_q;
    assign mdr_dataY     = y_q;
    assign res_result    = result_q;
    assign res_remainder = remainder_q;
    assign res_sign      = sign_q;
    assign res_err       = err_q;

endmodule

// File: tb/tb_mdr_arbiter.sv
// Directed bench for mdr_arbiter: a behavioural MDR engine plus a done-side scoreboard.
module tb_mdr_arbiter;

    localparam int unsigned WL = 16;
    localparam int unsigned MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1;
    logic [1:0]    op0, op1;
    logic [WL-1:0] x0, y0, x1, y1;
    logic          gnt0, gnt1, done0, done1;
    logic [WL-1:0] res_result, res_remainder;
    logic          res_sign, res_err, busy;
    logic [WL-1:0] mdr_dataX, mdr_dataY;
    logic [1:0]    mdr_op;
    logic          mdr_start;
    logic          mdr_ready;
    logic [WL-1:0] mdr_result, mdr_remainder;
    logic          mdr_sign;

    always #5 clk = ~clk;

    mdr_arbiter #(.WORD_LENGTH(WL), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res_result(res_result), .res_remainder(res_remainder),
        .res_sign(res_sign), .res_err(res_err), .busy(busy),
        .mdr_dataX(mdr_dataX), .mdr_dataY(mdr_dataY), .mdr_op(mdr_op),
        .mdr_start(mdr_start), .mdr_ready(mdr_ready),
        .mdr_result(mdr_result), .mdr_remainder(mdr_remainder), .mdr_sign(mdr_sign)
    );

    typedef struct packed {
        logic          who;
        logic [WL-1:0] res;
        logic [WL-1:0] rem;
        logic          sgn;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int   model_lat   = 3;
    logic model_level = 1'b0;
    logic model_never = 1'b0;
    int   m_cnt;
    exp_t pend;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine behaviour: 0 mul (lo/hi), 1 div (quot/rem), 2-3 add/sub with compare sign.
    function automatic exp_t mdr_fn(input logic who, input logic [1:0] op,
                                    input logic [WL-1:0] x, input logic [WL-1:0] y);
        exp_t          e;
        logic [2*WL-1:0] p;
        e     = '0;
        e.who = who;
        case (op)
            2'd0: begin
                p     = {{WL{1'b0}}, x} * {{WL{1'b0}}, y};
                e.res = p[WL-1:0];
                e.rem = p[2*WL-1:WL];
            end
            2'd1: begin
                if (y == '0) begin
                    e.res = '1;
                    e.rem = x;
                end else begin
                    e.res = x / y;
                    e.rem = x % y;
                end
            end
            default: begin
                e.res = x + y;
                e.rem = x - y;
                e.sgn = (x < y);
            end
        endcase
        return e;
    endfunction

    // Level mode keeps ready high after completion until one cycle after the next start.
    always @(posedge clk) begin
        if (reset) begin
            mdr_ready     <= 1'b0;
            mdr_result    <= '0;
            mdr_remainder <= '0;
            mdr_sign      <= 1'b0;
            m_cnt         <= 0;
        end else if (mdr_start) begin
            pend  <= mdr_fn(1'b0, mdr_op, mdr_dataX, mdr_dataY);
            m_cnt <= model_never ? 0 : model_lat;
            if (!model_level) mdr_ready <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mdr_ready     <= 1'b1;
                mdr_result    <= pend.res;
                mdr_remainder <= pend.rem;
                mdr_sign      <= pend.sgn;
            end else if (m_cnt == model_lat) begin
                mdr_ready <= 1'b0;
            end
        end else if (!model_level) begin
            mdr_ready <= 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (gnt0 || gnt1) begin
            check("gnt_onehot", 64'(gnt0 & gnt1), 64'(0));
            check("gnt_with_start", 64'(mdr_start), 64'(1));
        end
        if (done0 || done1) begin
            check("done_onehot", 64'(done0 & done1), 64'(0));
            check("done_expected", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_who", 64'(done1), 64'(e.who));
                check("sb_result", 64'(res_result), 64'(e.res));
                check("sb_remainder", 64'(res_remainder), 64'(e.rem));
                check("sb_sign", 64'(res_sign), 64'(e.sgn));
                check("sb_err", 64'(res_err), 64'(e.err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for_gnt(output int cyc);
        cyc = 0;
        while (!(gnt0 || gnt1) && cyc < 40) begin
            step();
            cyc++;
        end
        check("gnt_within_bound", 64'(gnt0 || gnt1), 64'(1));
    endtask

    task automatic wait_for_done(output int cyc);
        cyc = 0;
        while (!(done0 || done1) && cyc < 40) begin
            step();
            cyc++;
        end
        check("done_within_bound", 64'(done0 || done1), 64'(1));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pulses"}, 64'({gnt0, gnt1, done0, done1, mdr_start, busy}), 64'(0));
        check({tag, "_res"}, 64'({res_result, res_remainder, res_sign, res_err}), 64'(0));
        check({tag, "_mdr"}, 64'({mdr_dataX, mdr_dataY, mdr_op}), 64'(0));
    endtask

    initial begin
        int   cyc;
        exp_t e;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        step();
        step();
        check_reset_state("rst");
        reset = 1'b0;
        step();

        // Single request, engine ready 3 cycles after start sampling
        op0 = 2'd0; x0 = 16'd7; y0 = 16'd6; req0 = 1'b1;
        sb_q.push_back(mdr_fn(1'b0, 2'd0, 16'd7, 16'd6));
        step();
        check("single_gnt0", 64'({gnt0, gnt1}), 64'(2'b10));
        check("single_busy", 64'(busy), 64'(1));
        check("single_ops", 64'({mdr_dataX, mdr_dataY, mdr_op}), 64'({16'd7, 16'd6, 2'd0}));
        req0 = 1'b0;
        wait_for_done(cyc);
        check("single_latency", 64'(cyc), 64'(5));
        check("single_result", 64'({res_result, res_err}), 64'({16'd42, 1'b0}));
        step();
        check("single_idle", 64'(busy), 64'(0));

        // Reset during WAIT discards the job
        model_never = 1'b1;
        op0 = 2'd1; x0 = 16'd100; y0 = 16'd7; req0 = 1'b1;
        step();
        check("rstwait_gnt0", 64'(gnt0), 64'(1));
        req0 = 1'b0;
        step();
        step();
        check("rstwait_busy", 64'(busy), 64'(1));
        reset = 1'b1;
        step();
        check("rstwait_busy_low", 64'(busy), 64'(0));
        step();
        check_reset_state("rstwait");
        reset = 1'b0;
        model_never = 1'b0;
        model_lat = 1;
        step();
        op1 = 2'd1; x1 = 16'd100; y1 = 16'd7; req1 = 1'b1;
        sb_q.push_back(mdr_fn(1'b1, 2'd1, 16'd100, 16'd7));
        step();
        check("after_rst_gnt1", 64'({gnt0, gnt1}), 64'(2'b01));
        req1 = 1'b0;
        wait_for_done(cyc);
        check("min_latency", 64'(cyc), 64'(3));
        step();

        // Both requesters held: strict alternation starting with requester 0
        model_lat = 2;
        op0 = 2'd1; x0 = 16'd100; y0 = 16'd3;
        op1 = 2'd0; x1 = 16'd9;   y1 = 16'd11;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb_q.push_back(mdr_fn(1'b0, op0, x0, y0));
            else            sb_q.push_back(mdr_fn(1'b1, op1, x1, y1));
        end
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_for_gnt(cyc);
            check("rr_order", 64'(gnt1), 64'(i % 2));
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 60) begin
            step();
            cyc++;
        end
        check("rr_drained", 64'(sb_q.size()), 64'(0));
        step();

        // Level ready stays high into the next ISSUE/SETTLE
        model_level = 1'b1; model_lat = 3;
        op0 = 2'd2; x0 = 16'd3; y0 = 16'd10; req0 = 1'b1;
        sb_q.push_back(mdr_fn(1'b0, 2'd2, 16'd3, 16'd10));
        step();
        check("stale1_gnt0", 64'(gnt0), 64'(1));
        req0 = 1'b0;
        wait_for_done(cyc);
        check("stale1_latency", 64'(cyc), 64'(5));
        step();
        op1 = 2'd1; x1 = 16'd50; y1 = 16'd7; req1 = 1'b1;
        sb_q.push_back(mdr_fn(1'b1, 2'd1, 16'd50, 16'd7));
        step();
        check("stale2_gnt1", 64'(gnt1), 64'(1));
        req1 = 1'b0;
        wait_for_done(cyc);
        check("stale2_latency", 64'(cyc), 64'(5));
        model_level = 1'b0;
        step();

        // Engine never answers: abort with err after MAX_WAIT+1 WAIT cycles
        model_never = 1'b1;
        op0 = 2'd0; x0 = 16'd5; y0 = 16'd5; req0 = 1'b1;
        e = '0;
        e.err = 1'b1;
        sb_q.push_back(e);
        step();
        check("tmo_gnt0", 64'(gnt0), 64'(1));
        req0 = 1'b0;
        wait_for_done(cyc);
        check("tmo_latency", 64'(cyc), 64'(7));
        check("tmo_err", 64'({res_result, res_err}), 64'({16'd0, 1'b1}));
        step();
        model_never = 1'b0; model_lat = 2;
        op1 = 2'd0; x1 = 16'd300; y1 = 16'd300; req1 = 1'b1;
        sb_q.push_back(mdr_fn(1'b1, 2'd0, 16'd300, 16'd300));
        step();
        check("post_tmo_gnt1", 64'(gnt1), 64'(1));
        req1 = 1'b0;
        wait_for_done(cyc);
        check("post_tmo_err", 64'(res_err), 64'(0));
        step();

        // Operands frozen after grant; a request raised and dropped while busy is never seen
        model_lat = 3;
        op0 = 2'd0; x0 = 16'd11; y0 = 16'd12; req0 = 1'b1;
        sb_q.push_back(mdr_fn(1'b0, 2'd0, 16'd11, 16'd12));
        step();
        check("hold_gnt0", 64'(gnt0), 64'(1));
        req0 = 1'b0; op0 = 2'd1; x0 = 16'd999; y0 = 16'd1;
        cyc = 0;
        while (!done0 && cyc < 20) begin
            check("hold_ops", 64'({mdr_dataX, mdr_dataY, mdr_op}), 64'({16'd11, 16'd12, 2'd0}));
            if (cyc == 1) req1 = 1'b1;
            if (cyc == 3) req1 = 1'b0;
            step();
            cyc++;
        end
        check("hold_done0", 64'(done0), 64'(1));
        check("hold_ops_resp", 64'({mdr_dataX, mdr_op}), 64'({16'd11, 2'd0}));
        for (int i = 0; i < 3; i++) begin
            step();
            check("dropped_req_no_gnt", 64'({gnt1, busy}), 64'(0));
        end

        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule
